cordic_flow_ctrl: RTL and testbench

Flow-control wrapper that sits directly upstream and downstream of the pipelined circular-mode CORDIC sine/cosine stage. It accepts angle requests on a valid/ready interface and issues them to the CORDIC `start`/`func`/`a` inputs. The CORDIC pipeline has no stall, so the block collects each `valid`/`f` result into an in-order result FIFO and presents it on a valid/ready response interface. A credit counter caps requests in flight plus buffered results at the FIFO depth, so a non-stalling pipeline can never overflow the buffer.

---
 rtl/cordic_flow_ctrl.sv | 139 +++++++++++++
 tb/tb_cordic_flow_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_flow_ctrl.sv
// Valid/ready flow-control wrapper around a non-stalling CORDIC sin/cos pipeline.
// Optional request tagging is enabled by defining CORDIC_FLOW_TAG_EN.
module cordic_flow_ctrl #(
  parameter int W     = 12,
  parameter int DEPTH = 4
`ifdef CORDIC_FLOW_TAG_EN
  ,
  parameter int TAG_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_func,
  input  logic [2*W-1:0]   req_angle,
`ifdef CORDIC_FLOW_TAG_EN
  input  logic [TAG_W-1:0] req_tag,
`endif
  output logic             cor_start,
  output logic             cor_func,
  output logic [2*W-1:0]   cor_a,
  output logic [2*W-1:0]   cor_b,
  input  logic             cor_valid,
  input  logic [W-1:0]     cor_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
`ifdef CORDIC_FLOW_TAG_EN
  output logic [TAG_W-1:0] rsp_tag,
`endif
  output logic             busy,
  output logic             ovf_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  logic [CW-1:0]  outst_q, outst_d, count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic           cor_start_q, cor_start_d, cor_func_q, cor_func_d;
  logic [2*W-1:0] cor_a_q, cor_a_d;
  logic           ovf_q, ovf_d;
  logic           req_fire, rsp_fire, full, drop, push;

  // Ready and valid are gated by rst_n so they read 0 throughout a synchronous reset.
  assign req_ready = (outst_q != DEPTH_C) && rst_n;
  assign rsp_valid = (count_q != '0) && rst_n;
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign full      = (count_q == DEPTH_C);
  assign drop      = cor_valid && ((full && !rsp_fire) || (outst_q == count_q));
  assign push      = cor_valid && !drop;

  // NOTE: next-state logic is combinational with every target defaulted first, so no latches form.
  always_comb begin
    outst_d     = outst_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cor_start_d = req_fire;
    cor_func_d  = cor_func_q;
    cor_a_d     = cor_a_q;
    ovf_d       = ovf_q | drop;
    if (req_fire && !rsp_fire) outst_d = outst_q + ONE_C;
    if (!req_fire && rsp_fire) outst_d = outst_q - ONE_C;
    if (push && !rsp_fire) count_d = count_q + ONE_C;
    if (!push && rsp_fire) count_d = count_q - ONE_C;
    if (push)     wr_ptr_d = wr_ptr_q + PONE_C;
    if (rsp_fire) rd_ptr_d = rd_ptr_q + PONE_C;
    if (req_fire) begin
      cor_func_d = req_func;
      cor_a_d    = req_angle;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outst_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cor_start_q <= 1'b0;
      cor_func_q  <= 1'b0;
      cor_a_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      outst_q     <= outst_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cor_start_q <= cor_start_d;
      cor_func_q  <= cor_func_d;
      cor_a_q     <= cor_a_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: storage is not reset; occupancy and pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cor_f;
  end

  assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q] : '0;
  assign cor_start = cor_start_q;
  assign cor_func  = cor_func_q;
  assign cor_a     = cor_a_q;
  assign cor_b     = '0;
  assign busy      = (outst_q != '0) && rst_n;
  assign ovf_err   = ovf_q;

`ifdef CORDIC_FLOW_TAG_EN
  // Tag queue tracks outstanding requests, so its occupancy mirrors outst_q.
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [PW-1:0]    tag_wr_q, tag_rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      if (req_fire) tag_wr_q <= tag_wr_q + PONE_C;
      if (rsp_fire) tag_rd_q <= tag_rd_q + PONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= req_tag;
  end

  assign rsp_tag = rsp_valid ? tag_mem_q[tag_rd_q] : '0;
`endif

endmodule

// File: tb/tb_cordic_flow_ctrl.sv
// Directed bench for cordic_flow_ctrl with a 13-cycle in-order CORDIC model.
// Tag checks are compiled in when CORDIC_FLOW_TAG_EN is defined.
module tb_cordic_flow_ctrl;
  localparam int W   = 12;
  localparam int LAT = 13;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready, req_func;
  logic [2*W-1:0] req_angle;
  logic           cor_start, cor_func, cor_valid;
  logic [2*W-1:0] cor_a, cor_b;
  logic [W-1:0]   cor_f;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           busy, ovf_err;
`ifdef CORDIC_FLOW_TAG_EN
  logic [3:0]     req_tag, rsp_tag;
`endif

  logic           inj_v;
  logic [W-1:0]   inj_f;
  logic [LAT-1:0] pv;
  logic [W-1:0]   pf [LAT];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cordic_flow_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func), .req_angle(req_angle),
`ifdef CORDIC_FLOW_TAG_EN
    .req_tag(req_tag),
`endif
    .cor_start(cor_start), .cor_func(cor_func), .cor_a(cor_a), .cor_b(cor_b),
    .cor_valid(cor_valid), .cor_f(cor_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef CORDIC_FLOW_TAG_EN
    .rsp_tag(rsp_tag),
`endif
    .busy(busy), .ovf_err(ovf_err)
  );

  // CORDIC stand-in: result = angle[11:0] ^ (sine ? 0x800 : 0x3FF), LAT cycles after start.
  always @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], cor_start};
      pf[0] <= cor_a[W-1:0] ^ (cor_func ? 12'h800 : 12'h3FF);
      for (int i = 1; i < LAT; i++) pf[i] <= pf[i-1];
    end
  end
  assign cor_valid = pv[LAT-1] | inj_v;
  assign cor_f     = inj_v ? inj_f : pf[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] bp_exp [6] = '{12'h3EF, 12'h811, 12'h3ED, 12'h813, 12'h3EB, 12'h815};
  logic [W-1:0] cb_exp [4] = '{12'h3CE, 12'h3CD, 12'h3CC, 12'h840};

  initial begin
    int idx, acc, npop, slot, pop0_slot, acc4_slot;
    logic found, pcv;

    rst_n = 1'b0; req_valid = 1'b0; req_func = 1'b0; req_angle = '0;
    rsp_ready = 1'b0; inj_v = 1'b0; inj_f = '0;
`ifdef CORDIC_FLOW_TAG_EN
    req_tag = '0;
`endif
    repeat (3) tick();

    // Reset values
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cor_b", cor_b, 0);
    check("rst_cor_start", cor_start, 0);
    check("rst_ovf", ovf_err, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", req_ready, 1);

    // Single cosine request of angle 0
    req_valid = 1'b1; req_func = 1'b0; req_angle = '0;
    tick();
    req_valid = 1'b0;
    check("single_start", cor_start, 1);
    check("single_func", cor_func, 0);
    check("single_a", cor_a, 0);
    check("single_busy", busy, 1);
    tick();
    check("single_start_pulse", cor_start, 0);
    found = 1'b0; pcv = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      pcv = cor_valid;
      tick();
      if (rsp_valid) found = 1'b1;
    end
    check("single_rsp_timeout", found, 1);
    check("single_rsp_after_cv", pcv, 1);
    check("single_data", rsp_data, 12'h3FF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("single_busy_fall", busy, 0);
    check("single_rsp_gone", rsp_valid, 0);
    check("single_data_zero", rsp_data, 0);

    // Backpressure: six back-to-back requests, four credits
    idx = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_angle = 24'h000010 + 24'(idx); req_func = idx[0];
      if (req_ready) begin acc++; idx++; end
      tick();
    end
    check("bp_accepted", acc, 4);
    check("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1; npop = 0; slot = 0; pop0_slot = -1; acc4_slot = -1;
    while (npop < 6 && slot < 300) begin
      req_valid = (idx < 6); req_angle = 24'h000010 + 24'(idx); req_func = idx[0];
      if (req_valid && req_ready) begin
        if (idx == 4) acc4_slot = slot;
        idx++;
      end
      if (rsp_valid) begin
        check($sformatf("bp_data%0d", npop), rsp_data, bp_exp[npop]);
        if (npop == 0) pop0_slot = slot;
        npop++;
      end
      tick();
      slot++;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("bp_pops", npop, 6);
    check("bp_issued", idx, 6);
    check("bp_credit_next_cycle", acc4_slot, pop0_slot + 1);
    check("bp_busy_end", busy, 0);

    // Credit boundary: full credits, pop and request in the same cycle
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_func = 1'b0; req_angle = 24'h000030 + 24'(k);
      tick();
    end
    req_valid = 1'b0;
    repeat (20) tick();
    check("cb_full_ready", req_ready, 0);
    rsp_ready = 1'b1; req_valid = 1'b1; req_func = 1'b1; req_angle = 24'h000040;
    check("cb_same_cycle_ready", req_ready, 0);
    check("cb_head", rsp_data, 12'h3CF);
    tick();
    check("cb_no_accept", cor_start, 0);
    check("cb_ready_next", req_ready, 1);
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check("cb_accept", cor_start, 1);
    check("cb_accept_a", cor_a, 24'h000040);
    check("cb_accept_func", cor_func, 1);
    check("cb_ready_low_again", req_ready, 0);
    rsp_ready = 1'b1; npop = 0;
    for (int n = 0; n < 100 && busy; n++) begin
      if (rsp_valid && npop < 4) begin
        check($sformatf("cb_data%0d", npop), rsp_data, cb_exp[npop]);
        npop++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    check("cb_pops", npop, 4);
    check("cb_busy_end", busy, 0);

`ifdef CORDIC_FLOW_TAG_EN
    // Tags 3, 5, 7 held back then drained in order
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_func = 1'b0; req_angle = 24'h000020 + 24'(k);
      req_tag = 4'(3 + 2 * k);
      tick();
    end
    req_valid = 1'b0;
    repeat (20) tick();
    check("tag_idle_zero", 32'(rsp_tag), 3);
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("tag%0d", k), 32'(rsp_tag), 3 + 2 * k);
      check($sformatf("tag_data%0d", k), rsp_data, 12'h3DF - 12'(k));
      tick();
    end
    rsp_ready = 1'b0;
    check("tag_empty_zero", 32'(rsp_tag), 0);
`endif

    // Spurious result while idle
    check("sp_idle", busy, 0);
    inj_v = 1'b1; inj_f = 12'h123;
    tick();
    inj_v = 1'b0;
    check("sp_ovf_set", ovf_err, 1);
    check("sp_no_rsp", rsp_valid, 0);
    repeat (3) tick();
    check("sp_ovf_sticky", ovf_err, 1);
    rst_n = 1'b0;
    tick();
    check("sp_ovf_cleared", ovf_err, 0);
    rst_n = 1'b1;
    tick();

    // Reset with three requests outstanding
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_func = 1'b1; req_angle = 24'h000050 + 24'(k);
      tick();
    end
    req_valid = 1'b0;
    tick();
    check("rm_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    check("rm_busy", busy, 0);
    check("rm_rsp_valid", rsp_valid, 0);
    check("rm_cor_start", cor_start, 0);
    check("rm_ready_in_reset", req_ready, 0);
    rst_n = 1'b1;
    tick();
    check("rm_ready_after", req_ready, 1);
    repeat (20) tick();
    check("rm_no_late_ovf", ovf_err, 0);
    check("rm_no_late_rsp", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
